// File: rtl/float_mul_dispatch_pkg.sv
// rtl/float_mul_dispatch_pkg.sv - shared float widths and dispatch FSM state type
package float_mul_dispatch_pkg;

  localparam int float_width      = 32;
  localparam int float_exp_width  = 8;
  localparam int float_mant_width = 23;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } e_dispatch_state;

endpackage

// File: rtl/float_mul_dispatch_if.sv
// rtl/float_mul_dispatch_if.sv - request, multiplier and response signals of the dispatch stage
interface float_mul_dispatch_if #(
  parameter int float_width = 32,
  parameter int tag_width   = 4
);

  logic                   in_valid;
  logic                   in_ready;
  logic [float_width-1:0] in_a;
  logic [float_width-1:0] in_b;
  logic [tag_width-1:0]   in_tag;

  logic                   mul_req;
  logic [float_width-1:0] mul_a;
  logic [float_width-1:0] mul_b;
  logic                   mul_ack;
  logic [float_width-1:0] mul_out;

  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [float_width-1:0] rsp_out;
  logic [tag_width-1:0]   rsp_tag;
  logic                   rsp_err;

  logic                   busy;

  // Dispatch stage view.
  modport slave (
    input  in_valid, in_a, in_b, in_tag, mul_ack, mul_out, rsp_ready,
    output in_ready, mul_req, mul_a, mul_b, rsp_valid, rsp_out, rsp_tag, rsp_err, busy
  );

  // Core / multiplier / consumer view.
  modport master (
    output in_valid, in_a, in_b, in_tag, mul_ack, mul_out, rsp_ready,
    input  in_ready, mul_req, mul_a, mul_b, rsp_valid, rsp_out, rsp_tag, rsp_err, busy
  );

endinterface

// File: rtl/float_req_fifo.sv
// rtl/float_req_fifo.sv - request FIFO holding {tag, a, b}; power-of-two depth, wrapping pointers
module float_req_fifo #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [width-1:0]             push_data,
  input  logic                         pop,
  output logic [width-1:0]             pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(depth+1)-1:0]   count
);

  localparam int ptr_w   = $clog2(depth);
  localparam int count_w = $clog2(depth + 1);

  logic [width-1:0] mem [depth];
  logic [ptr_w-1:0] wr_ptr;
  logic [ptr_w-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == count_w'(depth));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/float_mul_dispatch.sv
// rtl/float_mul_dispatch.sv - issues queued multiply requests one at a time and buffers the tagged result
module float_mul_dispatch #(
  parameter int float_width = float_mul_dispatch_pkg::float_width,
  parameter int tag_width   = 4,
  parameter int depth       = 4,
  parameter int timeout     = 40
) (
  input logic                 clk,
  input logic                 rst,
  float_mul_dispatch_if.slave bus
);

  import float_mul_dispatch_pkg::*;

  localparam int entry_w = tag_width + 2 * float_width;
  localparam int cnt_w   = $clog2(timeout + 1);
  localparam int count_w = $clog2(depth + 1);

  e_dispatch_state        state;
  logic [cnt_w-1:0]       wait_cnt;
  logic [tag_width-1:0]   tag_q;

  logic                   mul_req_q;
  logic [float_width-1:0] mul_a_q;
  logic [float_width-1:0] mul_b_q;
  logic                   rsp_valid_q;
  logic [float_width-1:0] rsp_out_q;
  logic [tag_width-1:0]   rsp_tag_q;
  logic                   rsp_err_q;

  logic [entry_w-1:0]     head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [count_w-1:0]     fifo_count;
  logic                   push;
  logic                   rsp_free;
  logic                   issue;

  assign push     = bus.in_valid && !fifo_full;
  // The response buffer counts as free when it is being drained this cycle.
  assign rsp_free = !rsp_valid_q || bus.rsp_ready;
  assign issue    = (state == IDLE) && !fifo_empty && rsp_free;

  float_req_fifo #(
    .width (entry_w),
    .depth (depth)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({bus.in_tag, bus.in_a, bus.in_b}),
    .pop       (issue),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      tag_q       <= '0;
      mul_req_q   <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_out_q   <= '0;
      rsp_tag_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (rsp_valid_q && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (issue) begin
            tag_q     <= head[entry_w-1 -: tag_width];
            mul_a_q   <= head[2*float_width-1 -: float_width];
            mul_b_q   <= head[float_width-1:0];
            mul_req_q <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          mul_req_q <= 1'b0;
          wait_cnt  <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          if (bus.mul_ack) begin
            rsp_valid_q <= 1'b1;
            rsp_out_q   <= bus.mul_out;
            rsp_tag_q   <= tag_q;
            rsp_err_q   <= 1'b0;
            state       <= IDLE;
          end else if (wait_cnt == cnt_w'(timeout)) begin
            // Abort keeps the request's tag so the consumer knows which op was lost.
            rsp_valid_q <= 1'b1;
            rsp_out_q   <= '0;
            rsp_tag_q   <= tag_q;
            rsp_err_q   <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = !fifo_full;
  assign bus.mul_req   = mul_req_q;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_out   = rsp_out_q;
  assign bus.rsp_tag   = rsp_tag_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = (state != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_float_mul_dispatch.sv
// tb/tb_float_mul_dispatch.sv - scoreboard bench for float_mul_dispatch with a stub multiplier
module tb_float_mul_dispatch;

  typedef struct {
    logic [31:0] out;
    logic [3:0]  tag;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   vectors = 0;
  int   errors = 0;
  exp_t q[$];

  int   exp_req_cyc = -1;
  int   ignore_n = 0;
  bit   spur = 1'b0;
  int   countdown = 0;
  logic [31:0] held_out;

  float_mul_dispatch_if #(.float_width(32), .tag_width(4)) bus ();

  float_mul_dispatch #(
    .float_width (32),
    .tag_width   (4),
    .depth       (4),
    .timeout     (40)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Hand-computed products for the operand pairs used below.
  function automatic logic [31:0] product(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ab;
    ab = {a, b};
    if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return 32'h0000_0000;
    case (ab)
      64'h40000000_40400000: return 32'h40C0_0000;
      64'h3FC00000_3FC00000: return 32'h4010_0000;
      64'hC0000000_3F000000: return 32'hBF80_0000;
      default:               return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Stub multiplier: ack one cycle after req for a zero exponent, 27 cycles otherwise.
  initial begin
    bus.mul_ack = 1'b0;
    bus.mul_out = '0;
    forever begin
      @(negedge clk);
      bus.mul_ack = 1'b0;
      bus.mul_out = '0;
      if (bus.mul_req) begin
        chk("req_outside_wait", countdown, 0);
        if (exp_req_cyc >= 0) begin
          chk("req_cycle", cyc, exp_req_cyc);
          exp_req_cyc = -1;
        end
      end
      if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          bus.mul_ack = 1'b1;
          bus.mul_out = held_out;
        end
      end else if (bus.mul_req) begin
        if (ignore_n > 0) begin
          ignore_n--;
        end else begin
          countdown = (bus.mul_a[30:23] == 8'h00 || bus.mul_b[30:23] == 8'h00) ? 1 : 27;
          held_out  = product(bus.mul_a, bus.mul_b);
        end
      end else if (spur) begin
        spur        = 1'b0;
        bus.mul_ack = 1'b1;
        bus.mul_out = 32'h1234_5678;
      end
    end
  end

  initial begin
    bit prev_valid;
    bit prev_fired;
    exp_t e;
    prev_valid = 1'b0;
    prev_fired = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        prev_valid = 1'b0;
        prev_fired = 1'b0;
      end else begin
        if (bus.rsp_valid && (!prev_valid || prev_fired)) begin
          if (q.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL rsp_unexpected: got out %h tag %0d err %0d, expected no response", bus.rsp_out, bus.rsp_tag, bus.rsp_err);
          end else if (q[0].cyc >= 0) begin
            chk("rsp_cycle", cyc, q[0].cyc);
          end
        end
        if (bus.rsp_valid && bus.rsp_ready && q.size() > 0) begin
          e = q.pop_front();
          chk("rsp_out", bus.rsp_out, e.out);
          chk("rsp_tag", {28'h0, bus.rsp_tag}, {28'h0, e.tag});
          chk("rsp_err", {31'h0, bus.rsp_err}, {31'h0, e.err});
        end
        prev_valid = bus.rsp_valid;
        prev_fired = bus.rsp_valid && bus.rsp_ready;
      end
    end
  end

  // Called at a negedge; lat >= 0 means the DUT is idle and empty, so timing is exact.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                      input logic [31:0] eo, input logic ee, input int lat, input bit expect_rsp);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tag;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      vectors++;
      errors++;
      $display("FAIL send_tag%0d: in_ready still 0 after %0d cycles, expected 1", tag, n);
    end else begin
      if (expect_rsp) q.push_back('{eo, tag, ee, (lat < 0) ? -1 : cyc + lat});
      if (lat >= 0) exp_req_cyc = cyc + 2;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((bus.busy || bus.rsp_valid || q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy || bus.rsp_valid || q.size() != 0) begin
      vectors++;
      errors++;
      $display("FAIL %s: busy %0d rsp_valid %0d pending %0d after %0d cycles, expected idle", name, bus.busy, bus.rsp_valid, q.size(), budget);
    end
  endtask

  task automatic check_reset(input string name);
    chk({name, "_in_ready"}, {31'h0, bus.in_ready}, 32'd1);
    chk({name, "_mul_req"}, {31'h0, bus.mul_req}, 32'd0);
    chk({name, "_mul_a"}, bus.mul_a, 32'd0);
    chk({name, "_mul_b"}, bus.mul_b, 32'd0);
    chk({name, "_rsp_valid"}, {31'h0, bus.rsp_valid}, 32'd0);
    chk({name, "_rsp_out"}, bus.rsp_out, 32'd0);
    chk({name, "_rsp_tag"}, {28'h0, bus.rsp_tag}, 32'd0);
    chk({name, "_rsp_err"}, {31'h0, bus.rsp_err}, 32'd0);
    chk({name, "_busy"}, {31'h0, bus.busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n;
    int reqs;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_tag    = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset("reset");

    // 2.0 x 3.0 on an idle unit.
    send(32'h40000000, 32'h40400000, 4'd3, 32'h40C00000, 1'b0, 30, 1'b1);
    wait_idle("idle_after_t1", 60);

    // Zero operand takes the short path.
    send(32'h00000000, 32'h40000000, 4'd1, 32'h00000000, 1'b0, 4, 1'b1);
    wait_idle("idle_after_t2", 20);

    // Back-to-back, returned in order.
    send(32'h3FC00000, 32'h3FC00000, 4'd0, 32'h40100000, 1'b0, 30, 1'b1);
    send(32'hC0000000, 32'h3F000000, 4'd1, 32'hBF800000, 1'b0, -1, 1'b1);
    wait_idle("idle_after_t3", 100);

    // Fill the FIFO behind a busy multiplier.
    send(32'h40000000, 32'h40400000, 4'd8, 32'h40C00000, 1'b0, 30, 1'b1);
    for (int t = 9; t <= 12; t++) send(32'h40000000, 32'h40400000, 4'(t), 32'h40C00000, 1'b0, -1, 1'b1);
    chk("in_ready_full", {31'h0, bus.in_ready}, 32'd0);
    chk("busy_full", {31'h0, bus.busy}, 32'd1);
    send(32'h40000000, 32'h40400000, 4'd13, 32'h40C00000, 1'b0, -1, 1'b1);
    wait_idle("idle_after_t4", 300);

    // Silent multiplier for one op: abort, then the queued op completes.
    ignore_n = 1;
    send(32'h40000000, 32'h40400000, 4'd5, 32'h00000000, 1'b1, 44, 1'b1);
    send(32'h40000000, 32'h40400000, 4'd6, 32'h40C00000, 1'b0, -1, 1'b1);
    wait_idle("idle_after_t5", 150);
    spur = 1'b1;
    repeat (4) @(negedge clk);
    chk("spur_rsp_valid", {31'h0, bus.rsp_valid}, 32'd0);
    chk("spur_busy", {31'h0, bus.busy}, 32'd0);

    // Consumer stalls with a second request queued.
    bus.rsp_ready = 1'b0;
    send(32'h40000000, 32'h40400000, 4'd2, 32'h40C00000, 1'b0, 30, 1'b1);
    send(32'h00000000, 32'h40000000, 4'd4, 32'h00000000, 1'b0, -1, 1'b1);
    n = 0;
    while (!bus.rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.mul_req) reqs++;
      chk("hold_rsp_valid", {31'h0, bus.rsp_valid}, 32'd1);
      chk("hold_rsp_out", bus.rsp_out, 32'h40C00000);
      chk("hold_rsp_tag", {28'h0, bus.rsp_tag}, 32'd2);
    end
    chk("hold_no_second_req", reqs, 0);
    chk("hold_busy", {31'h0, bus.busy}, 32'd1);
    bus.rsp_ready = 1'b1;
    wait_idle("idle_after_hold", 40);

    // Reset mid-WAIT discards the op; the late ack is ignored.
    send(32'h40000000, 32'h40400000, 4'd7, 32'h0, 1'b0, 30, 1'b0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset("mid_wait_rst");
    rst = 1'b0;
    repeat (35) @(negedge clk);
    chk("late_ack_rsp_valid", {31'h0, bus.rsp_valid}, 32'd0);
    chk("late_ack_busy", {31'h0, bus.busy}, 32'd0);
    chk("scoreboard_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
